// File: rtl/cache_ctrl_wt.sv
// Direct-mapped, write-through, no-write-allocate cache controller between the CPU load/store port and the
// cache bus unit. Holds the tag/valid array and line data RAM; bursts a line on a cached read miss, forwards
// every store as a single write-through, and issues single reads for uncached loads.
// Ports: clk/rst (sync, active-high); cpu_* request/response side; flush; read_line_req/read_req/
// write_through_req/pa/wt_data request side to the bus unit; line_data/addr_count/line_write/trans_rdy/
// bus_error response side from the bus unit.
module cache_ctrl_wt #(
   parameter int BUS_WIDTH  = 8,
   parameter int BUS_ADDR   = 24,
   parameter int LINE_WORDS = 256,
   parameter int LINES      = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cpu_req,
   input  logic                            cpu_we,
   input  logic                            cpu_uncached,
   input  logic [BUS_ADDR-1:0]             cpu_addr,
   input  logic [BUS_WIDTH-1:0]            cpu_wdata,
   output logic [BUS_WIDTH-1:0]            cpu_rdata,
   output logic                            cpu_rdy,
   output logic                            cpu_err,
   input  logic                            flush,
   output logic                            read_line_req,
   output logic                            read_req,
   output logic [BUS_WIDTH/8-1:0]          write_through_req,
   output logic [BUS_ADDR-1:0]             pa,
   output logic [BUS_WIDTH-1:0]            wt_data,
   input  logic [BUS_WIDTH-1:0]            line_data,
   input  logic [$clog2(LINE_WORDS)-1:0]   addr_count,
   input  logic                            line_write,
   input  logic                            trans_rdy,
   input  logic                            bus_error
);

   localparam int OFF  = $clog2(LINE_WORDS);
   localparam int IDX  = $clog2(LINES);
   localparam int TAG  = BUS_ADDR - IDX - OFF;
   localparam int STRB = BUS_WIDTH / 8;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOOKUP    = 3'd1;
   localparam logic [2:0] S_REFILL    = 3'd2;
   localparam logic [2:0] S_RD_SINGLE = 3'd3;
   localparam logic [2:0] S_WRITE     = 3'd4;

   logic [2:0]            state;
   logic                  req_we;
   logic                  req_unc;
   logic [BUS_ADDR-1:0]   req_addr;
   logic [BUS_WIDTH-1:0]  req_wdata;
   logic [TAG-1:0]        tags [LINES];
   logic [LINES-1:0]      valid;
   logic [BUS_WIDTH-1:0]  mem [LINES*LINE_WORDS];
   logic [BUS_WIDTH-1:0]  ram_q;
   logic [BUS_WIDTH-1:0]  rdata_q;

   logic [TAG-1:0]        req_tag;
   logic [IDX-1:0]        req_idx;
   logic [OFF-1:0]        req_off;
   logic                  hit;
   logic                  accept;
   logic                  refill_done;
   logic                  mem_we;
   logic [IDX+OFF-1:0]    mem_waddr;
   logic [BUS_WIDTH-1:0]  mem_wdat;
   logic                  ram_re;
   logic [IDX+OFF-1:0]    ram_raddr;

   assign req_tag = req_addr[BUS_ADDR-1 -: TAG];
   assign req_idx = req_addr[OFF +: IDX];
   assign req_off = req_addr[OFF-1:0];
   assign hit     = valid[req_idx] && (tags[req_idx] == req_tag) && !req_unc;

   // flush takes priority over a request arriving in the same IDLE cycle
   assign accept      = (state == S_IDLE) && cpu_req && !flush;
   assign refill_done = (state == S_REFILL) && trans_rdy && !bus_error;

   // Single RAM write port: burst beats during REFILL, or a store hit in LOOKUP.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = {req_idx, req_off};
      mem_wdat  = req_wdata;
      if (!rst) begin
         if (state == S_REFILL && line_write) begin
            mem_we    = 1'b1;
            mem_waddr = {req_idx, addr_count};
            mem_wdat  = line_data;
         end else if (state == S_LOOKUP && req_we && hit) begin
            mem_we = 1'b1;
         end
      end
   end

   // RAM is read on accept and again when a refill completes, so LOOKUP always sees fresh data.
   assign ram_re    = accept || refill_done;
   assign ram_raddr = (state == S_IDLE) ? cpu_addr[OFF+IDX-1:0] : {req_idx, req_off};

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdat;
      // bypass a beat landing on the word being re-read in the same cycle
      if (ram_re)
         ram_q <= (mem_we && mem_waddr == ram_raddr) ? mem_wdat : mem[ram_raddr];
      if (refill_done && !rst)
         tags[req_idx] <= req_tag;
      if (accept && !rst) begin
         req_we    <= cpu_we;
         req_unc   <= cpu_uncached;
         req_addr  <= cpu_addr;
         req_wdata <= cpu_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         valid   <= '0;
         rdata_q <= '0;
      end else begin
         if (cpu_rdy)
            rdata_q <= cpu_rdata;
         case (state)
            S_IDLE: begin
               if (flush)
                  valid <= '0;
               else if (cpu_req)
                  state <= S_LOOKUP;
            end
            S_LOOKUP: begin
               if (req_we)
                  state <= S_WRITE;
               else if (hit)
                  state <= S_IDLE;
               else if (req_unc)
                  state <= S_RD_SINGLE;
               else begin
                  valid[req_idx] <= 1'b0;
                  state          <= S_REFILL;
               end
            end
            S_REFILL: begin
               if (bus_error)
                  state <= S_IDLE;
               else if (trans_rdy) begin
                  valid[req_idx] <= 1'b1;
                  state          <= S_LOOKUP;
               end
            end
            S_RD_SINGLE, S_WRITE: begin
               if (bus_error || trans_rdy)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Completion pulses are decoded straight from state and bus response; bus_error wins over trans_rdy.
   always_comb begin
      cpu_rdy   = 1'b0;
      cpu_err   = 1'b0;
      cpu_rdata = rdata_q;
      case (state)
         S_LOOKUP: begin
            if (!req_we && hit) begin
               cpu_rdy   = 1'b1;
               cpu_rdata = ram_q;
            end
         end
         S_REFILL: cpu_err = bus_error;
         S_RD_SINGLE: begin
            if (bus_error)
               cpu_err = 1'b1;
            else if (trans_rdy) begin
               cpu_rdy   = 1'b1;
               cpu_rdata = line_data;
            end
         end
         S_WRITE: begin
            if (bus_error)
               cpu_err = 1'b1;
            else if (trans_rdy)
               cpu_rdy = 1'b1;
         end
         default: ;
      endcase
   end

   assign read_line_req     = (state == S_REFILL);
   assign read_req          = (state == S_RD_SINGLE);
   assign write_through_req = {STRB{state == S_WRITE}};
   assign pa                = (state == S_REFILL) ? {req_tag, req_idx, {OFF{1'b0}}} : req_addr;
   assign wt_data           = req_wdata;

endmodule

// File: tb/tb_cache_ctrl_wt.sv
// Bench for cache_ctrl_wt: a behavioural bus unit answers bursts/single reads/writes (with optional error
// injection), a vector table drives CPU accesses, and an expected-result queue is checked on each
// cpu_rdy/cpu_err pulse. Hand sequences cover flush and reset in the middle of a burst.
module tb_cache_ctrl_wt;

   localparam int LW = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, cpu_uncached, flush;
   logic [23:0] cpu_addr;
   logic [7:0]  cpu_wdata, cpu_rdata;
   logic        cpu_rdy, cpu_err;
   logic        read_line_req, read_req;
   logic [0:0]  write_through_req;
   logic [23:0] pa;
   logic [7:0]  wt_data, line_data;
   logic [7:0]  addr_count;
   logic        line_write, trans_rdy, bus_error;

   cache_ctrl_wt dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_uncached(cpu_uncached),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_rdy(cpu_rdy), .cpu_err(cpu_err), .flush(flush),
      .read_line_req(read_line_req), .read_req(read_req),
      .write_through_req(write_through_req), .pa(pa), .wt_data(wt_data),
      .line_data(line_data), .addr_count(addr_count), .line_write(line_write),
      .trans_rdy(trans_rdy), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // bus kinds: 0 none, 1 line burst, 2 single read, 3 write-through
   typedef struct {
      logic        we;
      logic        unc;
      logic [23:0] addr;
      logic [7:0]  wdata;
      logic        fl;
      int          err;      // -1 no error; burst: beat index of error; single/write: any >=0
      logic        xerr;
      logic [7:0]  xrdata;
      int          xbus;
      logic [23:0] xpa;
      int          xlat;     // 0 = latency unchecked
   } vec_t;

   typedef struct {
      logic       xerr;
      logic [7:0] xrdata;
      logic       chk_rdata;
   } exp_t;

   exp_t sbq[$];
   vec_t vecs[$];

   int          inj_err = -1;
   int          n_line = 0, n_single = 0, n_write = 0;
   logic [23:0] obs_pa = '0;
   logic [7:0]  obs_wt = '0;

   function automatic vec_t mk(input logic we, input logic unc, input logic [23:0] addr,
                               input logic [7:0] wd, input logic fl, input int err, input logic xerr,
                               input logic [7:0] xr, input int xbus, input logic [23:0] xpa,
                               input int xlat);
      vec_t v;
      v.we = we; v.unc = unc; v.addr = addr; v.wdata = wd; v.fl = fl; v.err = err;
      v.xerr = xerr; v.xrdata = xr; v.xbus = xbus; v.xpa = xpa; v.xlat = xlat;
      return v;
   endfunction

   // Bus unit model: burst data = word address[7:0]; single read data = pa[7:0]^0xC3.
   initial begin
      line_data = '0; addr_count = '0; line_write = 1'b0; trans_rdy = 1'b0; bus_error = 1'b0;
      forever begin
         @(negedge clk);
         line_write = 1'b0; trans_rdy = 1'b0; bus_error = 1'b0;
         if (int'(read_line_req) + int'(read_req) + int'(write_through_req[0]) > 1) begin
            failures++;
            $display("FAIL onehot: req lines line=%0b rd=%0b wt=%0b, required at most one high",
                     read_line_req, read_req, write_through_req);
         end
         if (read_line_req) begin
            n_line++;
            obs_pa = pa;
            for (int i = 0; i < LW; i++) begin
               logic [23:0] a;
               if (!read_line_req) break;
               if (inj_err == i) begin
                  bus_error = 1'b1;
                  break;
               end
               a = pa | 24'(i);
               line_write = 1'b1;
               addr_count = a[7:0];
               line_data  = a[7:0];
               @(negedge clk);
               line_write = 1'b0;
            end
            if (!bus_error && read_line_req)
               trans_rdy = 1'b1;
         end else if (read_req || write_through_req[0]) begin
            if (read_req) n_single++; else n_write++;
            obs_pa = pa;
            obs_wt = wt_data;
            repeat (2) @(negedge clk);
            checks++;
            if (!(read_req || write_through_req[0])) begin
               failures++;
               $display("FAIL req_held: request dropped before response rd=%0b wt=%0b, required held",
                        read_req, write_through_req);
            end
            if (read_req) begin
               line_data  = pa[7:0] ^ 8'hC3;
               // stray beat outside REFILL: must not land in the data RAM
               line_write = 1'b1;
               addr_count = pa[7:0];
            end
            trans_rdy = 1'b1;
            if (inj_err >= 0)
               bus_error = 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
      end
   endtask

   task automatic run(input vec_t v, input int id);
      exp_t e;
      int cyc, l0, s0, w0, kind;
      logic done, got_err;
      logic [7:0] got_rd;
      l0 = n_line; s0 = n_single; w0 = n_write;
      inj_err      = v.err;
      cpu_we       = v.we;
      cpu_uncached = v.unc;
      cpu_addr     = v.addr;
      cpu_wdata    = v.wdata;
      flush        = v.fl;
      cpu_req      = 1'b1;
      sbq.push_back('{v.xerr, v.xrdata, !v.we && !v.xerr});
      cyc = 0; done = 1'b0;
      while (!done && cyc < 3000) begin
         @(negedge clk); #1;
         flush = 1'b0;
         cyc++;
         if (cpu_rdy || cpu_err) done = 1'b1;
      end
      got_err = cpu_err;
      got_rd  = cpu_rdata;
      cpu_req = 1'b0;
      inj_err = -1;
      e = sbq.pop_front();
      if (!done) begin
         checks++; failures++;
         $display("FAIL timeout v%0d: no cpu_rdy/cpu_err after %0d cycles, required completion", id, cyc);
         return;
      end
      check($sformatf("err v%0d", id), 32'(got_err), 32'(e.xerr));
      if (e.chk_rdata)
         check($sformatf("rdata v%0d", id), 32'(got_rd), 32'(e.xrdata));
      kind = 0;
      if (n_line - l0 + n_single - s0 + n_write - w0 > 1) kind = 9;
      else if (n_line != l0) kind = 1;
      else if (n_single != s0) kind = 2;
      else if (n_write != w0) kind = 3;
      check($sformatf("buskind v%0d", id), 32'(kind), 32'(v.xbus));
      if (v.xbus != 0)
         check($sformatf("pa v%0d", id), 32'(obs_pa), 32'(v.xpa));
      if (v.xbus == 3)
         check($sformatf("wt_data v%0d", id), 32'(obs_wt), 32'(v.wdata));
      if (v.xlat != 0)
         check($sformatf("latency v%0d", id), 32'(cyc), 32'(v.xlat));
      @(negedge clk); #1;
      check($sformatf("pulse v%0d", id), 32'({cpu_rdy, cpu_err}), 32'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_uncached = 1'b0; flush = 1'b0;
      cpu_addr = '0; cpu_wdata = '0;
      repeat (3) @(negedge clk); #1;
      check("rst cpu_rdy", 32'(cpu_rdy), 0);
      check("rst cpu_err", 32'(cpu_err), 0);
      check("rst cpu_rdata", 32'(cpu_rdata), 0);
      check("rst read_line_req", 32'(read_line_req), 0);
      check("rst read_req", 32'(read_req), 0);
      check("rst write_through_req", 32'(write_through_req), 0);
      rst = 1'b0;
      @(negedge clk); #1;

      //               we    unc   addr        wdata  fl    err  xerr  xrd    bus pa          lat
      vecs.push_back(mk(1'b0, 1'b0, 24'h000010, 8'h00, 1'b0, -1, 1'b0, 8'h10, 1, 24'h000000, 0));
      vecs.push_back(mk(1'b0, 1'b0, 24'h000011, 8'h00, 1'b0, -1, 1'b0, 8'h11, 0, 24'h0,      1));
      vecs.push_back(mk(1'b1, 1'b0, 24'h000011, 8'hA5, 1'b0, -1, 1'b0, 8'h00, 3, 24'h000011, 0));
      vecs.push_back(mk(1'b0, 1'b0, 24'h000011, 8'h00, 1'b0, -1, 1'b0, 8'hA5, 0, 24'h0,      1));
      vecs.push_back(mk(1'b0, 1'b0, 24'h000411, 8'h00, 1'b0, -1, 1'b0, 8'h11, 1, 24'h000400, 0));
      vecs.push_back(mk(1'b0, 1'b0, 24'h000011, 8'h00, 1'b0, -1, 1'b0, 8'h11, 1, 24'h000000, 0));
      vecs.push_back(mk(1'b0, 1'b1, 24'h123456, 8'h00, 1'b0, -1, 1'b0, 8'h95, 2, 24'h123456, 0));
      vecs.push_back(mk(1'b0, 1'b0, 24'h000056, 8'h00, 1'b0, -1, 1'b0, 8'h56, 0, 24'h0,      1));
      vecs.push_back(mk(1'b1, 1'b1, 24'h000012, 8'h77, 1'b0, -1, 1'b0, 8'h00, 3, 24'h000012, 0));
      vecs.push_back(mk(1'b0, 1'b0, 24'h000012, 8'h00, 1'b0, -1, 1'b0, 8'h12, 0, 24'h0,      1));
      vecs.push_back(mk(1'b1, 1'b0, 24'h000100, 8'h3C, 1'b0, -1, 1'b0, 8'h00, 3, 24'h000100, 0));
      vecs.push_back(mk(1'b0, 1'b0, 24'h000100, 8'h00, 1'b0, -1, 1'b0, 8'h00, 1, 24'h000100, 0));
      vecs.push_back(mk(1'b0, 1'b0, 24'h0001FF, 8'h00, 1'b0, -1, 1'b0, 8'hFF, 0, 24'h0,      1));
      vecs.push_back(mk(1'b0, 1'b0, 24'h000320, 8'h00, 1'b0, 100, 1'b1, 8'h00, 1, 24'h000300, 0));
      vecs.push_back(mk(1'b0, 1'b0, 24'h000320, 8'h00, 1'b0, -1, 1'b0, 8'h20, 1, 24'h000300, 0));
      vecs.push_back(mk(1'b1, 1'b0, 24'h000320, 8'h99, 1'b0, 0,  1'b1, 8'h00, 3, 24'h000320, 0));
      vecs.push_back(mk(1'b0, 1'b0, 24'h000320, 8'h00, 1'b0, -1, 1'b0, 8'h99, 0, 24'h0,      1));
      vecs.push_back(mk(1'b0, 1'b1, 24'h000321, 8'h00, 1'b0, 0,  1'b1, 8'h00, 2, 24'h000321, 0));
      vecs.push_back(mk(1'b0, 1'b0, 24'h000057, 8'h00, 1'b1, -1, 1'b0, 8'h57, 1, 24'h000000, 0));

      for (int i = 0; i < vecs.size(); i++)
         run(vecs[i], i);

      // flush alone in IDLE, then a previously resident word must miss
      flush = 1'b1;
      @(negedge clk); #1;
      flush = 1'b0;
      run(mk(1'b0, 1'b0, 24'h000012, 8'h00, 1'b0, -1, 1'b0, 8'h12, 1, 24'h000000, 0), 100);

      // reset in the middle of a burst
      cpu_we = 1'b0; cpu_uncached = 1'b0; cpu_addr = 24'h000200; cpu_req = 1'b1;
      cyc = 0;
      while (!read_line_req && cyc < 20) begin
         @(negedge clk); #1;
         cyc++;
      end
      check("midburst started", 32'(read_line_req), 1);
      repeat (10) @(negedge clk);
      #1;
      rst = 1'b1;
      cpu_req = 1'b0;
      @(negedge clk); #1;
      check("midrst read_line_req", 32'(read_line_req), 0);
      check("midrst cpu_rdy", 32'({cpu_rdy, cpu_err}), 0);
      check("midrst cpu_rdata", 32'(cpu_rdata), 0);
      rst = 1'b0;
      @(negedge clk); #1;
      run(mk(1'b0, 1'b0, 24'h000013, 8'h00, 1'b0, -1, 1'b0, 8'h13, 1, 24'h000000, 0), 101);
      run(mk(1'b0, 1'b0, 24'h000210, 8'h00, 1'b0, -1, 1'b0, 8'h10, 1, 24'h000200, 0), 102);
      run(mk(1'b0, 1'b0, 24'h000211, 8'h00, 1'b0, -1, 1'b0, 8'h11, 0, 24'h0,      1), 103);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
